dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8x32 synchronous data memory (write and read both on posedge, read data registered).
- Serialises single-word read/write accesses from requester 0 (pipeline MEM stage) and requester 1 (debug/loader port).
- Drives the memory's address, write data, write strobe and read strobe, and returns read data with a per-port valid pulse.
- Guarantees the strobes are low outside the one issue cycle, so the unreset memory never sees spurious writes.

Parameters:
ADDR_W, 3, memory word-address width (depth 2^ADDR_W)
DATA_W, 32, data word width

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-high reset
req0  in  1  port 0 access request; held until gnt0 seen
we0  in  1  port 0 op: 1=write, 0=read; stable while req0
adr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 grant, one-cycle pulse in ISSUE
rvalid0  out  1  port 0 read data valid, one-cycle pulse
req1, we1, adr1, wdata1, gnt1, rvalid1  as port 0, for port 1
rdata  out  DATA_W  shared read data, meaningful only while rvalid0 or rvalid1
mem_adr  out  ADDR_W  to memory address
mem_wdata  out  DATA_W  to memory write data
mem_we  out  1  to memory write strobe
mem_re  out  1  to memory read strobe
mem_rdata  in  DATA_W  from memory registered read output

Behaviour:
- Reset (async, immediate): state=IDLE, rr_last=1 (port 0 wins first tie), owner=0. mem_adr, mem_wdata, mem_we, mem_re, gnt0/1 and rvalid0/1 are all 0. An in-flight access is abandoned: no gnt, no rvalid, and no memory write if reset asserts before the issue edge.
- States: IDLE, ISSUE, RESP.
- IDLE, no req: stay; all strobes 0.
- IDLE, exactly one req: that port wins.
- IDLE, both req: the port != rr_last wins.
- On a win, at the clock edge:
  - Register winner's adr/wdata into mem_adr/mem_wdata.
  - mem_we=we_w, mem_re=!we_w.
  - owner=winner, rr_last=winner; go to ISSUE.
- ISSUE (1 cycle):
  - gnt_owner=1 and memory strobes stable; the memory performs the access at the closing edge.
  - Next state: RESP if read, IDLE if write.
  - mem_we/mem_re clear at that edge; mem_adr/mem_wdata hold their last value.
- RESP (1 cycle): rvalid_owner=1, rdata=mem_rdata (passthrough); next state IDLE.
- Latency from req sampled in IDLE:
  - gnt in the following cycle.
  - Read data valid 2 cycles after the IDLE cycle.
  - Throughput: write every 2 cycles, read every 3 cycles.
- Requester rule: req is deasserted in the cycle after gnt unless a new access is intended. A req seen high in IDLE is always a new request.
- Changes to req/we/adr/wdata during ISSUE/RESP are ignored, because the access was latched at the IDLE edge.
- A loser's req stays pending. Its grant cannot be starved: on the next IDLE with both ports requesting, it wins.
- gnt0&gnt1 and rvalid0&rvalid1 are never 1 simultaneously. mem_we&mem_re is never 1.
- Read-after-write to the same address from either port returns the new data, since accesses are strictly serialised.
- Address wraps only by width; there is no range check.
- Outputs gnt/rvalid are decoded from registered state and owner. There are no combinational paths from req to memory outputs.

Test Plan:
- Reset: assert rst mid-ISSUE of a write (req0, we0=1, adr0=5, wdata0=0xDEADBEEF). Required: mem_we drops immediately, no gnt0, mem[5] unchanged, all outputs 0.
- Single write then read on port 0:
  - Write adr0=3, wdata0=0x12345678: gnt0 in cycle 2, mem_we=1 only in that cycle.
  - Then read adr0=3: gnt0, then rvalid0=1 with rdata=0x12345678 exactly 2 cycles after IDLE sample.
- Tie round-robin: req0 and req1 both reading (adr 1 and 2), held continuously after each grant. Required:
  - Grants alternate 0,1,0,1.
  - rvalid0/rvalid1 alternate with the matching data.
  - No cycle with both gnts.
- Late arrival: req1 rises during port 0's ISSUE. Required: port 0 completes; port 1 granted in the ISSUE following the next IDLE; rr_last=0 lets port 1 win even if req0 reasserts.
- Cross-port RAW: port 1 writes adr=7 with 0xA5A5A5A5, immediately followed by port 0 reading adr=7 (pending). Required: rvalid0 with rdata=0xA5A5A5A5.
- Hold-change: after gnt, the requester changes adr/wdata during ISSUE. Required: the memory uses the originally latched values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of the 8x32 synchronous data memory.
// Serialises single-word accesses from the MEM stage (port 0) and the debug/loader port (port 1).
module dmem_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic              rrLast;
    logic              rrLastNext;
    logic              owner;
    logic              ownerNext;
    logic [ADDR_W-1:0] adrQ;
    logic [ADDR_W-1:0] adrNext;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] wdataNext;
    logic              weQ;
    logic              weNext;
    logic              reQ;
    logic              reNext;

    logic              anyReq;
    logic              winner;
    logic              winWe;
    logic [ADDR_W-1:0] winAdr;
    logic [DATA_W-1:0] winWdata;

    // A tie goes to the port that was not served last.
    assign anyReq   = req0 | req1;
    assign winner   = (req0 & req1) ? ~rrLast : req1;
    assign winWe    = winner ? we1    : we0;
    assign winAdr   = winner ? adr1   : adr0;
    assign winWdata = winner ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rrLast <= 1'b1;
            owner  <= 1'b0;
            adrQ   <= '0;
            wdataQ <= '0;
            weQ    <= 1'b0;
            reQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            rrLast <= rrLastNext;
            owner  <= ownerNext;
            adrQ   <= adrNext;
            wdataQ <= wdataNext;
            weQ    <= weNext;
            reQ    <= reNext;
        end
    end

    always_comb begin
        stateNext  = state;
        rrLastNext = rrLast;
        ownerNext  = owner;
        adrNext    = adrQ;
        wdataNext  = wdataQ;
        weNext     = 1'b0;
        reNext     = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext  = ISSUE;
                    rrLastNext = winner;
                    ownerNext  = winner;
                    adrNext    = winAdr;
                    wdataNext  = winWdata;
                    weNext     = winWe;
                    reNext     = ~winWe;
                end
            end
            ISSUE: begin
                stateNext = reQ ? RESP : IDLE;
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Strobes come straight from flops so the memory never sees a glitch.
    assign mem_adr   = adrQ;
    assign mem_wdata = wdataQ;
    assign mem_we    = weQ;
    assign mem_re    = reQ;

    assign gnt0    = (state == ISSUE) & ~owner;
    assign gnt1    = (state == ISSUE) &  owner;
    assign rvalid0 = (state == RESP)  & ~owner;
    assign rvalid1 = (state == RESP)  &  owner;
    assign rdata   = (state == RESP) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-timing reference model.
// Includes a behavioural 8x32 memory with registered read data.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [2:0]  adr0, adr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic [2:0]  mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .adr0(adr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_adr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  adr;
        bit [31:0] d;
        int        gap;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    item_t cur[2];
    bit    active[2];
    bit    loaded[2];
    int    gapLeft[2];

    // Reference model: an access accepted at edge k occupies the memory
    // until edge k+2 (write) or k+3 (read); grant shows after edge k.
    logic [31:0] refMem [8];
    int          cyc;
    int          nextFree;
    bit          mRr;
    bit          rdPend;
    bit          rdPort;
    logic [31:0] rdData;
    bit          expG[2];
    bit          expRv[2];
    bit          expWe, expRe;
    logic [31:0] expRdata;
    logic [2:0]  expAdr;
    logic [31:0] expWd;

    task automatic model_edge();
        bit          w;
        bit          wWe;
        logic [2:0]  wAdr;
        logic [31:0] wD;
        cyc++;
        expRv[0] = 1'b0;
        expRv[1] = 1'b0;
        expRdata = '0;
        if (rdPend) begin
            expRv[rdPort] = 1'b1;
            expRdata      = rdData;
        end
        rdPend  = 1'b0;
        expG[0] = 1'b0;
        expG[1] = 1'b0;
        expWe   = 1'b0;
        expRe   = 1'b0;
        if (cyc >= nextFree && (req0 || req1)) begin
            w    = (req0 && req1) ? !mRr : req1;
            mRr  = w;
            wWe  = w ? we1 : we0;
            wAdr = w ? adr1 : adr0;
            wD   = w ? wdata1 : wdata0;
            expG[w] = 1'b1;
            expAdr  = wAdr;
            expWd   = wD;
            if (wWe) begin
                refMem[wAdr] = wD;
                expWe        = 1'b1;
                nextFree     = cyc + 2;
            end else begin
                rdPend   = 1'b1;
                rdPort   = w;
                rdData   = refMem[wAdr];
                expRe    = 1'b1;
                nextFree = cyc + 3;
            end
        end
    endtask

    task automatic compare();
        check("gnt0", gnt0, expG[0]);
        check("gnt1", gnt1, expG[1]);
        check("rvalid0", rvalid0, expRv[0]);
        check("rvalid1", rvalid1, expRv[1]);
        check("mem_we", mem_we, expWe);
        check("mem_re", mem_re, expRe);
        if (expRv[0] || expRv[1]) check("rdata", rdata, expRdata);
        if (expWe || expRe) begin
            check("mem_adr", mem_adr, expAdr);
            check("mem_wdata", mem_wdata, expWd);
        end
    endtask

    task automatic drive();
        bit g;
        for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? gnt0 : gnt1;
            if (active[p] && g) active[p] = 1'b0;
            if (!active[p]) begin
                if (!loaded[p]) begin
                    if (p == 0 && q0.size() > 0) begin
                        cur[0] = q0.pop_front();
                        loaded[0] = 1'b1;
                        gapLeft[0] = cur[0].gap;
                    end else if (p == 1 && q1.size() > 0) begin
                        cur[1] = q1.pop_front();
                        loaded[1] = 1'b1;
                        gapLeft[1] = cur[1].gap;
                    end
                end
                if (loaded[p]) begin
                    if (gapLeft[p] == 0) begin
                        active[p] = 1'b1;
                        loaded[p] = 1'b0;
                    end else begin
                        gapLeft[p]--;
                    end
                end
            end
        end
        req0 = active[0];
        req1 = active[1];
        we0    = active[0] ? cur[0].we  : 1'($urandom);
        adr0   = active[0] ? cur[0].adr : 3'($urandom);
        wdata0 = active[0] ? cur[0].d   : $urandom;
        we1    = active[1] ? cur[1].we  : 1'($urandom);
        adr1   = active[1] ? cur[1].adr : 3'($urandom);
        wdata1 = active[1] ? cur[1].d   : $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic item_t mk(input bit we, input bit [2:0] a, input bit [31:0] d, input int gap);
        item_t it;
        it.we  = we;
        it.adr = a;
        it.d   = d;
        it.gap = gap;
        return it;
    endfunction

    task automatic drained(input string tag);
        check(tag, {30'd0, active[1] | loaded[1], active[0] | loaded[0]}, 32'd0);
    endtask

    logic [31:0] keep5;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        mem_rdata = '0;
        keep5 = mem[5];
        rst = 1'b1;
        req0 = 0; we0 = 0; adr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; adr1 = '0; wdata1 = '0;
        #3;
        check("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
        check("rst_mem", {mem_we, mem_re, mem_adr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1; we0 = 1; adr0 = 3'd5; wdata0 = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("pre_rst_gnt0", gnt0, 1'b1);
        check("pre_rst_we", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_issue_we", mem_we, 1'b0);
        check("rst_issue_gnt", {gnt0, gnt1, rvalid0, rvalid1, mem_re}, 32'd0);
        check("rst_issue_adr", mem_adr, 3'd0);
        check("rst_issue_wd", mem_wdata, 32'd0);
        req0 = 0;
        @(posedge clk); #1;
        check("rst_mem5", mem[5], keep5);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) refMem[i] = mem[i];
        cyc = 0; nextFree = 0; mRr = 1'b1; rdPend = 1'b0;
        active = '{0, 0}; loaded = '{0, 0}; gapLeft = '{0, 0};

        q0.push_back(mk(1, 3'd3, 32'h12345678, 0));
        q0.push_back(mk(0, 3'd3, 32'h0, 0));
        drive();
        run(12);
        drained("drain_wr_rd");

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 3'd1, $urandom, 0));
            q1.push_back(mk(0, 3'd2, $urandom, 0));
        end
        drive();
        run(30);
        drained("drain_tie");

        q0.push_back(mk(0, 3'd4, 32'h0, 0));
        q0.push_back(mk(0, 3'd6, 32'h0, 0));
        q1.push_back(mk(0, 3'd2, 32'h0, 1));
        drive();
        run(15);
        drained("drain_late");

        q1.push_back(mk(1, 3'd7, 32'hA5A5A5A5, 0));
        q0.push_back(mk(0, 3'd7, 32'h0, 1));
        drive();
        run(12);
        drained("drain_raw");
        check("raw_mem7", mem[7], 32'hA5A5A5A5);

        for (int i = 0; i < 2000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0)
                q0.push_back(mk(1'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3)));
            if (q1.size() == 0 && $urandom_range(0, 2) != 0)
                q1.push_back(mk(1'($urandom), 3'($urandom), $urandom, $urandom_range(0, 3)));
            step();
        end
        run(20);
        drained("drain_rand");

        for (int i = 0; i < 8; i++) check($sformatf("mem%0d", i), mem[i], refMem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
